// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: reset-vector fetch, PC redirects, stall, halt and interrupt entry.
// Drives the PC mux/load/enable, the memory address source, the IR inject select and the IR flush.
module fetch_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  // external interrupt request; "int" is a reserved word, hence int_req
  input  logic              int_req,
  input  logic              stall,
  input  logic              hlt_dec,
  input  logic              redir_d,
  input  logic              redir_ex,
  input  logic              redir_mem,
  output logic [1:0]        pc_src,
  output logic              pc_load,
  output logic              pc_en,
  output logic              addr_src,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              sf1,
  output logic              flush_IR,
  output logic              int_ack,
  output logic              hlt
);

  typedef enum logic [2:0] {
    S_RVEC,
    S_RUN,
    S_INJ,
    S_IVEC,
    S_HALT
  } state_t;

  localparam logic [1:0] SRC_DATA_OUT = 2'b00;
  localparam logic [1:0] SRC_RB_D     = 2'b01;
  localparam logic [1:0] SRC_I_OUT    = 2'b10;
  localparam logic [1:0] SRC_RB_EX    = 2'b11;

  state_t state;
  state_t state_nxt;
  logic   int_q;
  logic   int_pend;
  logic   int_rise;
  logic   pend_now;

  // An edge seen this very cycle counts as pending so entry is not delayed a cycle.
  assign int_rise = int_req & ~int_q;
  assign pend_now = int_pend | int_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RVEC;
      int_q    <= 1'b0;
      int_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      int_q    <= int_req;
      int_pend <= (state_nxt == S_INJ) ? 1'b0 : (int_pend | int_rise);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_src    = SRC_DATA_OUT;
    pc_load   = 1'b0;
    pc_en     = 1'b0;
    addr_src  = 1'b0;
    vec_addr  = '0;
    sf1       = 1'b0;
    flush_IR  = 1'b0;
    int_ack   = 1'b0;
    hlt       = 1'b0;

    if (rst) begin
      state_nxt = S_RVEC;
      flush_IR  = 1'b1;
    end else begin
      unique case (state)
        S_RVEC: begin
          addr_src  = 1'b1;
          vec_addr  = RESET_VEC;
          pc_src    = SRC_I_OUT;
          pc_load   = 1'b1;
          flush_IR  = 1'b1;
          state_nxt = S_RUN;
        end

        S_RUN: begin
          if (redir_mem) begin
            pc_src   = SRC_DATA_OUT;
            pc_load  = 1'b1;
            flush_IR = 1'b1;
          end else if (redir_ex) begin
            pc_src   = SRC_RB_EX;
            pc_load  = 1'b1;
            flush_IR = 1'b1;
          end else if (redir_d) begin
            pc_src   = SRC_RB_D;
            pc_load  = 1'b1;
            flush_IR = 1'b1;
          end else if (hlt_dec) begin
            flush_IR  = 1'b1;
            state_nxt = S_HALT;
          end else if (stall) begin
            pc_en = 1'b0;
          end else if (pend_now) begin
            // Hold the PC so the injected return address is the next unfetched word.
            state_nxt = S_INJ;
          end else begin
            pc_en = 1'b1;
          end
        end

        S_INJ: begin
          sf1       = 1'b1;
          int_ack   = 1'b1;
          state_nxt = S_IVEC;
        end

        S_IVEC: begin
          addr_src  = 1'b1;
          vec_addr  = INT_VEC;
          pc_src    = SRC_I_OUT;
          pc_load   = 1'b1;
          flush_IR  = 1'b1;
          state_nxt = S_RUN;
        end

        S_HALT: begin
          hlt      = 1'b1;
          flush_IR = 1'b1;
          if (pend_now) state_nxt = S_INJ;
        end

        default: begin
          state_nxt = S_RVEC;
          flush_IR  = 1'b1;
        end
      endcase
    end
  end

endmodule
